// File: rtl/fft16_pkg.sv
// Shared constants, state encoding and field types for the 16-point FFT stage sequencer.
package fft16_pkg;
  localparam int LOG2N  = 4;
  localparam int STAGES = LOG2N;
  localparam int N_BF   = 1 << (LOG2N - 1);

  typedef logic [$clog2(STAGES)-1:0] stage_t;
  typedef logic [LOG2N-2:0]          bf_t;
  typedef logic [LOG2N-1:0]          addr_t;
  typedef logic [LOG2N-2:0]          tw_t;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_e;
endpackage

// File: rtl/fft16_stage_sequencer_if.sv
// Control/issue bundle between FFT control, the stage sequencer and the butterfly unit.
interface fft16_stage_sequencer_if;
  import fft16_pkg::*;

  logic   start;
  logic   bf_ready;
  logic   bf_valid;
  stage_t stage;
  bf_t    bf_idx;
  addr_t  addr_a;
  addr_t  addr_b;
  tw_t    tw_idx;
  logic   stage_last;
  logic   busy;
  logic   done;

  modport master (
    input  start, bf_ready,
    output bf_valid, stage, bf_idx, addr_a, addr_b, tw_idx, stage_last, busy, done
  );

  modport slave (
    output start, bf_ready,
    input  bf_valid, stage, bf_idx, addr_a, addr_b, tw_idx, stage_last, busy, done
  );
endinterface

// File: rtl/fft16_addr_gen.sv
// Combinational radix-2 DIT operand/twiddle address mapping for one (stage, butterfly) pair.
module fft16_addr_gen
  import fft16_pkg::*;
(
  input  stage_t stage,
  input  bf_t    bf_idx,
  output addr_t  addr_a,
  output addr_t  addr_b,
  output tw_t    tw_idx
);
  addr_t b_ext, half, j, g;

  // addr_a inserts a zero bit at position 'stage' into bf_idx; addr_b sets that bit.
  always_comb begin
    b_ext  = addr_t'(bf_idx);
    half   = addr_t'(1) << stage;
    j      = b_ext & (half - addr_t'(1));
    g      = b_ext >> stage;
    addr_a = ((g << stage) << 1) | j;
    addr_b = addr_a + half;
    tw_idx = tw_t'(j << (stage_t'(LOG2N - 1) - stage));
  end
endmodule

// File: rtl/fft16_stage_sequencer.sv
// Walks 4 stages x 8 butterflies, issuing operand/twiddle addresses with valid/ready
// and a fixed write-back drain gap between stages.
module fft16_stage_sequencer #(
  parameter int LOG2N  = 4,
  parameter int BF_LAT = 3
) (
  input logic clk,
  input logic rst,
  fft16_stage_sequencer_if.master bus
);
  import fft16_pkg::*;

  localparam int              GW         = (BF_LAT > 1) ? $clog2(BF_LAT) : 1;
  localparam logic [GW-1:0]   GAP_INIT   = GW'((BF_LAT > 0) ? BF_LAT - 1 : 0);
  localparam stage_t          LAST_STAGE = stage_t'(LOG2N - 1);
  localparam bf_t             LAST_BF    = bf_t'((1 << (LOG2N - 1)) - 1);

  state_e        state_q, state_d;
  stage_t        stage_q, stage_d;
  bf_t           bf_q, bf_d;
  logic [GW-1:0] gap_q, gap_d;

  logic  valid_q, valid_d, last_q, last_d, busy_q, busy_d, done_q, done_d;
  addr_t addr_a_q, addr_a_d, addr_b_q, addr_b_d;
  tw_t   tw_q, tw_d;

  addr_t nxt_a, nxt_b;
  tw_t   nxt_tw;
  logic  xfer, stage_end;

  // Addresses are computed from the next (stage, bf) so they register alongside them.
  fft16_addr_gen u_addr_gen (
    .stage  (stage_d),
    .bf_idx (bf_d),
    .addr_a (nxt_a),
    .addr_b (nxt_b),
    .tw_idx (nxt_tw)
  );

  always_comb begin
    state_d   = state_q;
    stage_d   = stage_q;
    bf_d      = bf_q;
    gap_d     = gap_q;
    stage_end = 1'b0;
    xfer      = valid_q & bus.bf_ready;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = ISSUE;
          stage_d = '0;
          bf_d    = '0;
        end
      end
      ISSUE: begin
        if (xfer) begin
          if (bf_q != LAST_BF) begin
            bf_d = bf_q + 1'b1;
          end else if (BF_LAT > 0) begin
            state_d = DRAIN;
            gap_d   = GAP_INIT;
          end else begin
            stage_end = 1'b1;
          end
        end
      end
      DRAIN: begin
        if (gap_q == '0) stage_end = 1'b1;
        else             gap_d = gap_q - 1'b1;
      end
      DONE: begin
        state_d = IDLE;
        stage_d = '0;
        bf_d    = '0;
      end
      default: state_d = IDLE;
    endcase

    if (stage_end) begin
      bf_d = '0;
      if (stage_q == LAST_STAGE) begin
        state_d = DONE;
      end else begin
        state_d = ISSUE;
        stage_d = stage_q + 1'b1;
      end
    end

    valid_d  = (state_d == ISSUE);
    busy_d   = (state_d == ISSUE) || (state_d == DRAIN);
    done_d   = (state_d == DONE);
    last_d   = valid_d && (bf_d == LAST_BF);
    addr_a_d = valid_d ? nxt_a  : '0;
    addr_b_d = valid_d ? nxt_b  : '0;
    tw_d     = valid_d ? nxt_tw : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      stage_q  <= '0;
      bf_q     <= '0;
      gap_q    <= '0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      addr_a_q <= '0;
      addr_b_q <= '0;
      tw_q     <= '0;
    end else begin
      state_q  <= state_d;
      stage_q  <= stage_d;
      bf_q     <= bf_d;
      gap_q    <= gap_d;
      valid_q  <= valid_d;
      last_q   <= last_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      addr_a_q <= addr_a_d;
      addr_b_q <= addr_b_d;
      tw_q     <= tw_d;
    end
  end

  assign bus.bf_valid   = valid_q;
  assign bus.stage      = stage_q;
  assign bus.bf_idx     = bf_q;
  assign bus.addr_a     = addr_a_q;
  assign bus.addr_b     = addr_b_q;
  assign bus.tw_idx     = tw_q;
  assign bus.stage_last = last_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
endmodule

// File: tb/tb_fft16_stage_sequencer.sv
// Scoreboard bench: stimulus queues expected issues per transform, negedge monitors pop and compare.
module tb_fft16_stage_sequencer;
  import fft16_pkg::*;

  localparam int LAT0 = 3;

  typedef struct { int s; int b; int a; int bb; int tw; int last; } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0, n_fail = 0, cyc = 0;
  exp_t q0[$], q1[$];
  int   len_q[$];
  int   spot [4][5] = '{'{0, 6, 12, 13, 0}, '{1, 3, 5, 7, 4}, '{2, 5, 9, 13, 2}, '{3, 5, 5, 13, 5}};

  fft16_stage_sequencer_if sq0();
  fft16_stage_sequencer_if sq1();

  fft16_stage_sequencer #(.LOG2N(4), .BF_LAT(LAT0)) dut0 (.clk(clk), .rst(rst), .bus(sq0.master));
  fft16_stage_sequencer #(.LOG2N(4), .BF_LAT(0))    dut1 (.clk(clk), .rst(rst), .bus(sq1.master));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  logic [19:0] out0;
  assign out0 = {sq0.busy, sq0.done, sq0.bf_valid, sq0.stage_last, sq0.stage, sq0.bf_idx,
                 sq0.addr_a, sq0.addr_b, sq0.tw_idx};

  // Upper leg: bf with a zero bit inserted at position s; twiddle = low bits scaled to 8 entries.
  function automatic exp_t mk(int s, int b);
    exp_t e;
    int half;
    half   = 1 << s;
    e.s    = s;
    e.b    = b;
    e.a    = (b / half) * 2 * half + (b % half);
    e.bb   = e.a + half;
    e.tw   = (b % half) * (8 / half);
    e.last = (b == 7) ? 1 : 0;
    return e;
  endfunction

  task automatic chk(string nm, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- monitor, BF_LAT=3 instance ----------------
  int          first0 = -1, gap0 = 0, xf0 = 0;
  bit          pend0 = 0, stl0 = 0;
  logic [19:0] snap0 = '0;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      first0 = -1; gap0 = 0; xf0 = 0; pend0 = 0; stl0 = 0;
    end else begin
      if (sq0.bf_valid) begin
        if (first0 < 0) first0 = cyc;
        if (pend0) begin chk("drain_gap", gap0, LAT0); pend0 = 0; end
        if (stl0) chk("stall_hold", int'(out0), int'(snap0));
        stl0  = !sq0.bf_ready;
        snap0 = out0;
        if (sq0.bf_ready) begin
          if (q0.size() == 0) chk("unexpected_issue", 1, 0);
          else begin
            e = q0.pop_front();
            chk("stage",      int'(sq0.stage),      e.s);
            chk("bf_idx",     int'(sq0.bf_idx),     e.b);
            chk("addr_a",     int'(sq0.addr_a),     e.a);
            chk("addr_b",     int'(sq0.addr_b),     e.bb);
            chk("tw_idx",     int'(sq0.tw_idx),     e.tw);
            chk("stage_last", int'(sq0.stage_last), e.last);
            chk("busy_issue", int'(sq0.busy),       1);
            for (int k = 0; k < 4; k++)
              if (int'(sq0.stage) == spot[k][0] && int'(sq0.bf_idx) == spot[k][1]) begin
                chk("spot_addr_a", int'(sq0.addr_a), spot[k][2]);
                chk("spot_addr_b", int'(sq0.addr_b), spot[k][3]);
                chk("spot_tw_idx", int'(sq0.tw_idx), spot[k][4]);
              end
            xf0++;
            if (sq0.stage_last) begin pend0 = 1; gap0 = 0; end
          end
        end
      end else if (sq0.busy && pend0) begin
        gap0++;
      end
      if (sq0.done) begin
        if (pend0) begin chk("drain_gap", gap0, LAT0); pend0 = 0; end
        chk("busy_at_done", int'(sq0.busy), 0);
        if (len_q.size() == 0) chk("unexpected_done", 1, 0);
        else chk("done_latency", cyc - first0, len_q.pop_front());
        chk("transfers", xf0, 32);
        first0 = -1; xf0 = 0;
      end
    end
  end

  // ---------------- monitor, BF_LAT=0 instance ----------------
  int first1 = -1, xf1 = 0, bub1 = 0;

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (sq1.bf_valid) begin
        if (first1 < 0) first1 = cyc;
        if (sq1.bf_ready) begin
          if (q1.size() == 0) chk("lat0_unexpected_issue", 1, 0);
          else begin
            e = q1.pop_front();
            chk("lat0_stage",  int'(sq1.stage),  e.s);
            chk("lat0_bf_idx", int'(sq1.bf_idx), e.b);
            chk("lat0_addr_a", int'(sq1.addr_a), e.a);
            chk("lat0_addr_b", int'(sq1.addr_b), e.bb);
            chk("lat0_tw_idx", int'(sq1.tw_idx), e.tw);
            xf1++;
          end
        end
      end else if (sq1.busy) begin
        bub1++;
      end
      if (sq1.done) begin
        chk("lat0_bubbles", bub1, 0);
        chk("lat0_done_latency", cyc - first1, 32);
        chk("lat0_transfers", xf1, 32);
        first1 = -1; xf1 = 0; bub1 = 0;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic start0(int extra);
    @(posedge clk); #1;
    for (int s = 0; s < 4; s++)
      for (int b = 0; b < 8; b++) q0.push_back(mk(s, b));
    len_q.push_back(32 + 4 * LAT0 + extra);
    sq0.start = 1'b1;
    @(posedge clk); #1 sq0.start = 1'b0;
  endtask

  task automatic wait_done0();
    bit got;
    got = 0;
    for (int i = 0; i < 300 && !got; i++) begin
      @(posedge clk); #1;
      if (sq0.done) got = 1;
    end
    if (!got) chk("done_timeout", 0, 1);
  endtask

  task automatic wait_issue0(int s, int b, output bit hit);
    hit = 0;
    for (int i = 0; i < 200 && !hit; i++) begin
      @(posedge clk); #1;
      if (sq0.bf_valid && int'(sq0.stage) == s && int'(sq0.bf_idx) == b) hit = 1;
    end
    if (!hit) chk("issue_target_timeout", 0, 1);
  endtask

  task automatic stall_at(int s, int b, int n);
    bit hit;
    wait_issue0(s, b, hit);
    if (hit) begin
      sq0.bf_ready = 1'b0;
      repeat (n) @(posedge clk);
      #1 sq0.bf_ready = 1'b1;
    end
  endtask

  initial begin
    bit hit, got1;
    sq0.start = 1'b0; sq0.bf_ready = 1'b1;
    sq1.start = 1'b0; sq1.bf_ready = 1'b1;
    repeat (3) @(posedge clk); #1;
    chk("reset_outputs", int'(out0), 0);
    rst = 1'b0;

    // full-speed transform, then start during the DONE cycle
    start0(0);
    wait_done0();
    sq0.start = 1'b1;
    @(posedge clk); #1 sq0.start = 1'b0;
    repeat (4) @(posedge clk); #1;
    chk("idle_after_done", int'(sq0.busy | sq0.bf_valid), 0);

    // backpressure at s1 b2 plus a start pulse while busy
    start0(5);
    fork
      stall_at(1, 2, 5);
      begin
        repeat (6) @(posedge clk);
        #1 sq0.start = 1'b1;
        @(posedge clk); #1 sq0.start = 1'b0;
      end
    join
    wait_done0();

    // async reset mid stage 2
    start0(0);
    wait_issue0(2, 3, hit);
    #1 rst = 1'b1;
    q0.delete();
    len_q.delete();
    #1 chk("reset_abort", int'(out0), 0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (5) @(posedge clk); #1;
    chk("idle_after_abort", int'(sq0.busy | sq0.done | sq0.bf_valid), 0);
    start0(0);
    wait_done0();

    // zero-drain instance
    @(posedge clk); #1;
    for (int s = 0; s < 4; s++)
      for (int b = 0; b < 8; b++) q1.push_back(mk(s, b));
    sq1.start = 1'b1;
    @(posedge clk); #1 sq1.start = 1'b0;
    got1 = 0;
    for (int i = 0; i < 200 && !got1; i++) begin
      @(posedge clk); #1;
      if (sq1.done) got1 = 1;
    end
    if (!got1) chk("lat0_done_timeout", 0, 1);

    repeat (3) @(posedge clk); #1;
    chk("queues_drained", q0.size() + q1.size() + len_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
